usb_buffer_arbiter: RTL
=======================

// Module: usb_buffer_arbiter
// PURPOSE
// - Owns the shared 64-byte single-port endpoint data buffer and arbitrates it between 4 requesters:
//   host write (AHB store_tx_data path), host read (get_rx_data path), USB RX write and USB TX read.
// - Maintains FIFO read/write pointers and buffer_occupancy; services the AHB-lite USB slave's clear.
// - Sits between the AHB slave register block, the USB RX/TX packet engines and the buffer SRAM.
// PARAMETERS
// - DEPTH   64  buffer entries; power of two
// - ADDR_W  6   log2(DEPTH)
// - DATA_W  8   byte width
// PORTS
// - clk               in   1       system clock, all logic on rising edge
// - rst               in   1       asynchronous, active-high reset
// - clear             in   1       synchronous flush request (level), from AHB slave
// - hw_req/hw_ack     in/out 1     host write request / ack; hw_data in [DATA_W-1:0]
// - hr_req/hr_ack     in/out 1     host read request / ack (ack = hr_data valid)
// - hr_data           out  DATA_W  host read data
// - uw_req/uw_ack     in/out 1     USB RX write request / ack; uw_data in [DATA_W-1:0]
// - ur_req/ur_ack     in/out 1     USB TX read request / ack (ack = ur_data valid)
// - ur_data           out  DATA_W  USB TX read data
// - mem_addr          out  ADDR_W  SRAM address
// - mem_wen/mem_ren   out  1       SRAM write / read strobe (mutually exclusive)
// - mem_wdata         out  DATA_W  SRAM write data
// - mem_rdata         in   DATA_W  SRAM read data, valid 1 cycle after mem_ren
// - buffer_occupancy  out  ADDR_W+1 entries held, 0..DEPTH
// - overrun/underrun  out  1       1-cycle pulse: write refused (full) / read refused (empty)
// BEHAVIOUR
// - Reset: all acks, strobes, pulses 0; hr_data/ur_data/mem_* 0; pointers 0; occupancy 0; FSM IDLE;
//   RR pointer -> host write. Reset mid-read discards in-flight data, no ack issued.
// - Handshake: requester raises req, holds req/data stable until ack. Write ack = grant cycle
//   (mem_wen same cycle). Read: grant cycle drives mem_ren; ack + data next cycle from mem_rdata.
//   Requester drops req in ack cycle; a reader with a read in flight is ineligible for grant.
// - Arbitration: one grant per cycle, 4-way round robin, order HW,HR,UW,UR; after a grant,
//   highest priority passes to the next requester. Back-to-back grants allowed (reads pipelined).
// - FSM: IDLE (no eligible req) -> GRANT (grant issued each cycle while reqs pending) -> IDLE;
//   any state + clear -> FLUSH (1 cycle: pointers, occupancy, RR pointer reset; in-flight read
//   acked with data 0; no grants) -> IDLE. clear wins over all same-cycle requests.
// - Full (occupancy==DEPTH): write grant is still issued, ack pulses, mem_wen stays 0, overrun
//   pulses, data dropped. Empty (occupancy==0): read grant acks next cycle with data 0,
//   mem_ren stays 0, underrun pulses.
// - Pointers: ADDR_W bits, wrap DEPTH-1 -> 0. Occupancy +1 on accepted write, -1 on accepted read;
//   never both in one cycle (single port). Occupancy updates in the cycle after the grant.
// STRUCTURE
// - Package usb_buf_pkg: requester enum {REQ_HW,REQ_HR,REQ_UW,REQ_UR}, arbiter FSM state enum,
//   DEPTH/ADDR_W/DATA_W constants.
// - Sub-module usb_rr_arbiter: 4-way round-robin, eligible vector in, one-hot grant out, pointer
//   advance on grant, sync reset of pointer on flush.
// - Top: FSM, pointers/occupancy, mem mux, read-return pipe stage, status pulses.
// TESTING
// - Reset then 3 host writes 0xA1,0xA2,0xA3 -> hw_ack each cycle, mem_addr 0,1,2, occupancy 3.
// - Then ur_req x3 -> ur_data 0xA1,0xA2,0xA3, each 1 cycle after grant, occupancy 0.
// - hw_req, hr_req, uw_req, ur_req all high from reset, 4 bytes preloaded -> grants HW,HR,UW,UR.
// - 64 UW writes then 1 more -> 65th acked, overrun pulse, occupancy stays 64; write pointer wraps to 0.
// - hr_req with occupancy 0 -> hr_ack next cycle, hr_data 0x00, underrun pulse, mem_ren 0.
// - clear asserted same cycle as hw_req with occupancy 10 -> no grant, FLUSH, occupancy 0, then HW served.

Source files
------------

// File: rtl/usb_buf_pkg.sv
// Shared constants and types for the USB endpoint buffer arbiter.
// Requester ids double as round-robin slot indices, so their order matters.
package usb_buf_pkg;
    localparam int DEPTH   = 64;
    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 8;
    localparam int NUM_REQ = 4;

    typedef enum logic [1:0] {
        REQ_HW = 2'd0,
        REQ_HR = 2'd1,
        REQ_UW = 2'd2,
        REQ_UR = 2'd3
    } req_e;

    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_GRANT = 2'd1;
    localparam arb_state_t ST_FLUSH = 2'd2;

    function automatic logic is_rd(req_e r);
        return (r == REQ_HR) || (r == REQ_UR);
    endfunction
endpackage

// File: rtl/usb_rr_arbiter.sv
// 4-way round-robin: the slot after the last grant has top priority.
// The pointer returns to the host-write slot on reset and on flush.
module usb_rr_arbiter
    import usb_buf_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [NUM_REQ-1:0] eligible,
    output logic [NUM_REQ-1:0] grant,
    output logic [1:0]         grant_idx,
    output logic               grant_vld
);
    logic [1:0] ptr;
    logic [1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = ptr;
        grant_vld = 1'b0;
        idx       = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ptr + 2'(k);
            if (!grant_vld && eligible[idx]) begin
                grant_vld  = 1'b1;
                grant_idx  = idx;
                grant[idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= 2'd0;
        else if (flush)
            ptr <= 2'd0;
        else if (grant_vld)
            ptr <= grant_idx + 2'd1;
    end
endmodule

// File: rtl/usb_buffer_arbiter.sv
// Owns the shared endpoint FIFO buffer: arbitrates four requesters onto one
// single-port SRAM, tracks pointers/occupancy and handles the flush request.
module usb_buffer_arbiter
    import usb_buf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              hw_req,
    output logic              hw_ack,
    input  logic [DATA_W-1:0] hw_data,
    input  logic              hr_req,
    output logic              hr_ack,
    output logic [DATA_W-1:0] hr_data,
    input  logic              uw_req,
    output logic              uw_ack,
    input  logic [DATA_W-1:0] uw_data,
    input  logic              ur_req,
    output logic              ur_ack,
    output logic [DATA_W-1:0] ur_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic              mem_ren,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W:0]   buffer_occupancy,
    output logic              overrun,
    output logic              underrun
);
    arb_state_t         state;
    logic [ADDR_W-1:0]  wptr, rptr;
    logic [ADDR_W:0]    occ;
    logic               rd_vld, rd_zero;
    req_e               rd_who;

    logic [NUM_REQ-1:0] req_vec, busy, eligible, grant;
    logic [1:0]         grant_idx;
    logic               grant_vld, allow, full, empty;
    logic               g_wr, g_rd, wr_ok, rd_ok;
    logic [DATA_W-1:0]  ret_data;

    assign req_vec = {ur_req, uw_req, hr_req, hw_req};
    assign allow   = !clear && (state != ST_FLUSH);

    // A reader whose data is still in the return stage may not be re-granted.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_busy
        assign busy[i] = rd_vld && (rd_who == req_e'(i));
    end

    assign eligible = allow ? (req_vec & ~busy) : '0;

    usb_rr_arbiter u_rr (
        .clk       (clk),
        .rst       (rst),
        .flush     (clear),
        .eligible  (eligible),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    assign full  = (occ == (ADDR_W+1)'(DEPTH));
    assign empty = (occ == '0);
    assign g_wr  = grant_vld && !is_rd(req_e'(grant_idx));
    assign g_rd  = grant_vld &&  is_rd(req_e'(grant_idx));
    assign wr_ok = g_wr && !full;
    assign rd_ok = g_rd && !empty;

    assign mem_wen   = wr_ok;
    assign mem_ren   = rd_ok;
    assign mem_addr  = wr_ok ? wptr : (rd_ok ? rptr : '0);
    assign mem_wdata = !wr_ok ? '0 : ((req_e'(grant_idx) == REQ_HW) ? hw_data : uw_data);

    assign hw_ack = grant[REQ_HW];
    assign uw_ack = grant[REQ_UW];
    assign hr_ack = rd_vld && (rd_who == REQ_HR);
    assign ur_ack = rd_vld && (rd_who == REQ_UR);

    // Empty reads and reads landing on a flush return zero.
    assign ret_data = (rd_zero || clear) ? '0 : mem_rdata;
    assign hr_data  = hr_ack ? ret_data : '0;
    assign ur_data  = ur_ack ? ret_data : '0;

    assign buffer_occupancy = occ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            wptr     <= '0;
            rptr     <= '0;
            occ      <= '0;
            rd_vld   <= 1'b0;
            rd_zero  <= 1'b0;
            rd_who   <= REQ_HW;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state    <= clear ? ST_FLUSH : (grant_vld ? ST_GRANT : ST_IDLE);
            rd_vld   <= g_rd;
            rd_zero  <= !rd_ok;
            rd_who   <= req_e'(grant_idx);
            overrun  <= g_wr && full;
            underrun <= g_rd && empty;
            if (clear) begin
                wptr <= '0;
                rptr <= '0;
                occ  <= '0;
            end else if (wr_ok) begin
                wptr <= wptr + 1'b1;
                occ  <= occ + 1'b1;
            end else if (rd_ok) begin
                rptr <= rptr + 1'b1;
                occ  <= occ - 1'b1;
            end
        end
    end
endmodule
